// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the two-master bus arbiter
//
// Holds the device-ID enum used by the address decoder, the arbiter FSM state
// enum, the bus geometry constants and the default access timeout.
package bus_pkg;

    localparam int AW                     = 16;
    localparam int NUM_DEV                = 7;
    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic [2:0] {
        DRAM  = 3'd0,
        DROM  = 3'd1,
        DMAT  = 3'd2,
        DINT  = 3'd3,
        DREG  = 3'd4,
        DEXEC = 3'd5,
        DSPI  = 3'd6,
        NONE  = 3'd7
    } dev_id_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/bus_decode.sv
// rtl/bus_decode.sv - address decoder mapping a bus address to a device ID
//
// Ports:
//   addr  in  AW  latched transaction address
//   wr    in  1   latched direction (1 = write)
//   rd    out 1   read strobe qualifier (~wr)
//   wr_o  out 1   write strobe qualifier (wr)
//   hit   out 1   address maps to a device
//   did   out 3   device ID, NONE on a miss
module bus_decode
    import bus_pkg::*;
(
    input  logic [AW-1:0] addr,
    input  logic          wr,
    output logic          rd,
    output logic          wr_o,
    output logic          hit,
    output dev_id_e       did
);

    always_comb begin
        rd   = ~wr;
        wr_o = wr;
        hit  = 1'b1;
        // Each device owns one 4 KB window selected by the top nibble.
        case (addr[15:12])
            4'h0:    did = DRAM;
            4'h1:    did = DROM;
            4'h2:    did = DMAT;
            4'h3:    did = DINT;
            4'h4:    did = DREG;
            4'h5:    did = DEXEC;
            4'h6:    did = DSPI;
            default: begin
                did = NONE;
                hit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin arbiter driving seven devices
//
// Optional feature macro: BUS_TIMEOUT_EN (abort ACCESS after TIMEOUT_CYCLES).
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   m_req/m_wr          per-master request and direction
//   m_addr/m_wdata      per-master address and write data
//   m_gnt               one-hot grant for the whole transaction
//   m_done/m_err        one-cycle completion / error pulses
//   m_rdata             read data, valid with m_done
//   dev_sel             one-hot device select
//   dev_rd/dev_wr       device access strobes
//   dev_addr/dev_wdata  latched address and write data
//   dev_rdata/dev_ready selected device read data, per-device completion
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int DW             = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           m_req,
    input  logic [1:0]           m_wr,
    input  logic [1:0][AW-1:0]   m_addr,
    input  logic [1:0][DW-1:0]   m_wdata,
    output logic [1:0]           m_gnt,
    output logic [1:0]           m_done,
    output logic [1:0]           m_err,
    output logic [DW-1:0]        m_rdata,
    output logic [NUM_DEV-1:0]   dev_sel,
    output logic                 dev_rd,
    output logic                 dev_wr,
    output logic [AW-1:0]        dev_addr,
    output logic [DW-1:0]        dev_wdata,
    input  logic [DW-1:0]        dev_rdata,
    input  logic [NUM_DEV-1:0]   dev_ready
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e          state_q, state_d;
    logic [1:0]      gnt_q, gnt_d;
    logic            idx_q, idx_d;      // master owning the current transaction
    logic            prio_q, prio_d;    // master favoured on a simultaneous request
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [1:0]      done_q, done_d;
    logic [1:0]      err_q, err_d;
    logic [DW-1:0]   rdata_q, rdata_d;

`ifdef BUS_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    logic               dec_rd, dec_wr, dec_hit;
    dev_id_e            dec_did;
    logic [NUM_DEV-1:0] sel_vec;
    logic               in_access;
    logic               ready_hit;
    logic               pick;

    bus_decode u_decode (
        .addr (addr_q),
        .wr   (wr_q),
        .rd   (dec_rd),
        .wr_o (dec_wr),
        .hit  (dec_hit),
        .did  (dec_did)
    );

    assign sel_vec   = dec_hit ? (NUM_DEV'(1) << dec_did) : '0;
    assign in_access = (state_q == ACCESS);
    // Masking with the select vector ignores ready from unselected devices.
    assign ready_hit = |(dev_ready & sel_vec);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        prio_d  = prio_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 2'b00;
        err_d   = 2'b00;
        rdata_d = rdata_q;
        pick    = 1'b0;
`ifdef BUS_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                gnt_d = 2'b00;
                if (|m_req) begin
                    pick    = (&m_req) ? prio_q : m_req[1];
                    idx_d   = pick;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    wr_d    = m_wr[pick];
                    addr_d  = m_addr[pick];
                    wdata_d = m_wdata[pick];
                    state_d = ACCESS;
`ifdef BUS_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            ACCESS: begin
                if (!dec_hit) begin
                    state_d = DONE;
                    done_d  = gnt_q;
                    err_d   = gnt_q;
                    rdata_d = '0;
                end else if (ready_hit) begin
                    state_d = DONE;
                    done_d  = gnt_q;
                    rdata_d = dec_rd ? dev_rdata : '0;
                end
`ifdef BUS_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d = DONE;
                    done_d  = gnt_q;
                    err_d   = gnt_q;
                    rdata_d = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                prio_d  = ~idx_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            idx_q   <= 1'b0;
            prio_q  <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 2'b00;
            err_q   <= 2'b00;
            rdata_q <= '0;
`ifdef BUS_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            prio_q  <= prio_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
`ifdef BUS_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign m_gnt     = gnt_q;
    assign m_done    = done_q;
    assign m_err     = err_q;
    assign m_rdata   = rdata_q;
    assign dev_sel   = in_access ? sel_vec : '0;
    assign dev_rd    = in_access & dec_hit & dec_rd;
    assign dev_wr    = in_access & dec_hit & dec_wr;
    assign dev_addr  = addr_q;
    assign dev_wdata = wdata_q;

endmodule
